// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single line-wide Data_Memory port between two line-fill
//   requesters (port 0 = dcache, port 1 = icache/prefetcher) using the memory
//   enable/write/ack handshake. Round-robin arbitration, one transaction per
//   grant, a dead cycle after each grant so the memory can re-arm, and a
//   per-grant watchdog that aborts a grant the memory never acknowledges.
//
// Ports
//   clk_i, rst_i            clock (rising edge), synchronous active-high reset
//   reqN_enable_i           request, held high until reqN_ack_o
//   reqN_write_i            1 = write line, 0 = read line
//   reqN_addr_i/data_i      line address and write data
//   reqN_ack_o              1-cycle completion pulse
//   reqN_data_o             read data, qualified by reqN_ack_o
//   mem_enable_o/write_o/addr_o/data_o   request side of Data_Memory
//   mem_ack_i/data_i        response side of Data_Memory
//   grant_o                 one-hot current grant {g1,g0}, 00 when idle
//   timeout_o               sticky watchdog flag, cleared only by reset
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req0_enable_i,
    input  logic              req0_write_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_data_i,
    output logic              req0_ack_o,
    output logic [DATA_W-1:0] req0_data_o,

    input  logic              req1_enable_i,
    input  logic              req1_write_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_data_i,
    output logic              req1_ack_o,
    output logic [DATA_W-1:0] req1_data_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,

    output logic [1:0]        grant_o,
    output logic              timeout_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StGnt0,
        StGnt1,
        StTurn
    } state_e;

    state_e          state_q;
    logic            last_grant_q;
    logic [CntW-1:0] wd_cnt_q;
    logic            timeout_q;
    logic [1:0]      grant_q;
    logic            mem_enable_q;
    logic            wd_expire;

    // Last cycle of the watchdog window; an ack in this same cycle still wins.
    assign wd_expire = (wd_cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            wd_cnt_q     <= '0;
            timeout_q    <= 1'b0;
            grant_q      <= 2'b00;
            mem_enable_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // On a tie, port 0 wins when port 1 was served last.
                    if (req0_enable_i && (!req1_enable_i || last_grant_q)) begin
                        state_q      <= StGnt0;
                        grant_q      <= 2'b01;
                        mem_enable_q <= 1'b1;
                        wd_cnt_q     <= '0;
                    end else if (req1_enable_i) begin
                        state_q      <= StGnt1;
                        grant_q      <= 2'b10;
                        mem_enable_q <= 1'b1;
                        wd_cnt_q     <= '0;
                    end
                end
                StGnt0, StGnt1: begin
                    if (mem_ack_i || wd_expire) begin
                        state_q      <= StTurn;
                        grant_q      <= 2'b00;
                        mem_enable_q <= 1'b0;
                        last_grant_q <= (state_q == StGnt1);
                        if (!mem_ack_i) begin
                            timeout_q <= 1'b1;
                        end
                    end else if (wd_cnt_q != '1) begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
                end
                StTurn: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Request path muxes and ack routing; a requester that dropped its enable
    // mid-grant gets no ack pulse even though the memory ack is consumed.
    always_comb begin
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        req0_ack_o  = 1'b0;
        req1_ack_o  = 1'b0;
        unique case (state_q)
            StGnt0: begin
                mem_write_o = req0_write_i;
                mem_addr_o  = req0_addr_i;
                mem_data_o  = req0_data_i;
                req0_ack_o  = mem_ack_i & req0_enable_i;
            end
            StGnt1: begin
                mem_write_o = req1_write_i;
                mem_addr_o  = req1_addr_i;
                mem_data_o  = req1_data_i;
                req1_ack_o  = mem_ack_i & req1_enable_i;
            end
            default: begin
            end
        endcase
    end

    assign mem_enable_o = mem_enable_q;
    assign grant_o      = grant_q;
    assign timeout_o    = timeout_q;
    assign req0_data_o  = mem_data_i;
    assign req1_data_o  = mem_data_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. A small Data_Memory model answers
//   each grant after a programmable number of enable cycles (0 = never) and
//   stores written lines. Inputs are driven and outputs sampled at negedge.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 256;
    localparam int unsigned TO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_en = 1'b0, req0_wr = 1'b0, req1_en = 1'b0, req1_wr = 1'b0;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
    logic          req0_ack, req1_ack;
    logic [DW-1:0] req0_rdata, req1_rdata;
    logic          mem_en, mem_wr, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [1:0]    grant;
    logic          timeout;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_enable_i(req0_en),
        .req0_write_i (req0_wr),
        .req0_addr_i  (req0_addr),
        .req0_data_i  (req0_wdata),
        .req0_ack_o   (req0_ack),
        .req0_data_o  (req0_rdata),
        .req1_enable_i(req1_en),
        .req1_write_i (req1_wr),
        .req1_addr_i  (req1_addr),
        .req1_data_i  (req1_wdata),
        .req1_ack_o   (req1_ack),
        .req1_data_o  (req1_rdata),
        .mem_enable_o (mem_en),
        .mem_write_o  (mem_wr),
        .mem_addr_o   (mem_addr),
        .mem_data_o   (mem_wdata),
        .mem_ack_i    (mem_ack),
        .mem_data_i   (mem_rdata),
        .grant_o      (grant),
        .timeout_o    (timeout)
    );

    // ---------------- memory model ----------------
    int            lat = 0;
    int            mem_cnt;
    logic          ack_inj = 1'b0;
    logic [DW-1:0] mem [64];

    // 0000_1111_2222_..._FFFF
    function automatic logic [DW-1:0] ramp();
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[255-16*i -: 16] = {4{4'(i)}};
        return r;
    endfunction

    // Ack lands in the lat-th cycle of enable.
    assign mem_ack   = ((lat != 0) && mem_en && (mem_cnt == lat - 1)) || ack_inj;
    assign mem_rdata = mem[mem_addr[10:5]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            mem[0]  <= ramp();
            mem_cnt <= 0;
        end else begin
            mem_cnt <= mem_en ? mem_cnt + 1 : 0;
            if (mem_ack && mem_en && mem_wr) mem[mem_addr[10:5]] <= mem_wdata;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [DW-1:0] obs,
                             input logic [DW-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic set_req(input int p, input logic en, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            req0_en = en; req0_wr = wr; req0_addr = a; req0_wdata = d;
        end else begin
            req1_en = en; req1_wr = wr; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        ack_inj = 1'b0;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // One transaction on port p; returns once the grant has ended and the
    // arbiter is back in IDLE. Bounded so a stuck DUT still terminates.
    task automatic do_txn(input int p, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int en_cyc, output int acks,
                          output logic [DW-1:0] rdata, output logic [1:0] first_gnt,
                          output logic first_wr, output logic [AW-1:0] first_addr);
        en_cyc = 0; acks = 0; rdata = '0;
        first_gnt = 2'b00; first_wr = 1'b0; first_addr = '0;
        set_req(p, 1'b1, wr, a, d);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 0) begin
                first_gnt = grant; first_wr = mem_wr; first_addr = mem_addr;
            end
            if (mem_en) en_cyc++;
            if ((p == 0) ? req0_ack : req1_ack) begin
                acks++;
                rdata = (p == 0) ? req0_rdata : req1_rdata;
            end
            if (en_cyc > 0 && !mem_en) break;
        end
        set_req(p, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
    endtask

    int            en_c, ac, a0, a1, n_ord;
    int            ord [4];
    logic [DW-1:0] rd;
    logic [1:0]    fg;
    logic          fw;
    logic [AW-1:0] fa;
    logic [1:0]    gtrace [7];

    initial begin
        // Reset state
        apply_reset();
        check_val("rst_grant", DW'(grant), DW'(2'b00));
        check_val("rst_enable", DW'(mem_en), '0);
        check_val("rst_timeout", DW'(timeout), '0);
        check_val("rst_acks", DW'({req1_ack, req0_ack}), '0);
        check_val("rst_mem_write", DW'(mem_wr), '0);

        // 1: port0 read of line 0, memory acks after 10 cycles
        lat = 10;
        do_txn(0, 1'b0, 32'h0, '0, en_c, ac, rd, fg, fw, fa);
        check_val("t1_latency_grant", DW'(fg), DW'(2'b01));
        check_val("t1_enable_cycles", DW'(en_c), DW'(10));
        check_val("t1_ack_pulses", DW'(ac), DW'(1));
        check_val("t1_read_data", rd, ramp());

        // 2: simultaneous requests after reset: port0 first, port1 after TURN+IDLE
        apply_reset();
        lat = 2;
        a0 = 0; a1 = 0;
        set_req(0, 1'b1, 1'b0, 32'h20, '0);
        set_req(1, 1'b1, 1'b0, 32'h40, '0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            gtrace[i] = grant;
            if (req0_ack) begin a0++; req0_en = 1'b0; end
            if (req1_ack) begin a1++; req1_en = 1'b0; end
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        check_val("t2_grant_c1", DW'(gtrace[0]), DW'(2'b01));
        check_val("t2_grant_turn", DW'(gtrace[2]), DW'(2'b00));
        check_val("t2_grant_idle", DW'(gtrace[3]), DW'(2'b00));
        check_val("t2_grant_c5", DW'(gtrace[4]), DW'(2'b10));
        check_val("t2_ack0", DW'(a0), DW'(1));
        check_val("t2_ack1", DW'(a1), DW'(1));
        @(negedge clk);

        // 3: both requesting continuously -> alternating service
        n_ord = 0;
        for (int i = 0; i < 4; i++) ord[i] = -1;
        set_req(0, 1'b1, 1'b0, 32'h20, '0);
        set_req(1, 1'b1, 1'b0, 32'h40, '0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (req0_ack && n_ord < 4) begin ord[n_ord] = 0; n_ord++; end
            if (req1_ack && n_ord < 4) begin ord[n_ord] = 1; n_ord++; end
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check_val("t3_count", DW'(n_ord), DW'(4));
        check_val("t3_order0", DW'(ord[0]), DW'(0));
        check_val("t3_order1", DW'(ord[1]), DW'(1));
        check_val("t3_order2", DW'(ord[2]), DW'(0));
        check_val("t3_order3", DW'(ord[3]), DW'(1));

        // 4: port1 writes line 0x0400, port0 reads it back
        lat = 3;
        do_txn(1, 1'b1, 32'h400, {32{8'hAB}}, en_c, ac, rd, fg, fw, fa);
        check_val("t4_grant", DW'(fg), DW'(2'b10));
        check_val("t4_mem_write", DW'(fw), DW'(1));
        check_val("t4_mem_addr", DW'(fa), DW'(32'h400));
        check_val("t4_wr_ack", DW'(ac), DW'(1));
        do_txn(0, 1'b0, 32'h400, '0, en_c, ac, rd, fg, fw, fa);
        check_val("t4_readback", rd, {32{8'hAB}});

        // Requester drops enable mid-grant: grant held, ack swallowed
        lat = 5;
        en_c = 0; a0 = 0;
        set_req(0, 1'b1, 1'b0, 32'h20, '0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_en) en_c++;
            if (req0_ack) a0++;
            if (i == 1) req0_en = 1'b0;
            if (en_c > 0 && !mem_en) break;
        end
        @(negedge clk);
        check_val("drop_enable_cycles", DW'(en_c), DW'(5));
        check_val("drop_no_ack", DW'(a0), '0);

        // Ack exactly on the watchdog boundary wins
        apply_reset();
        lat = 64;
        do_txn(1, 1'b0, 32'h20, '0, en_c, ac, rd, fg, fw, fa);
        check_val("bound_ack", DW'(ac), DW'(1));
        check_val("bound_enable_cycles", DW'(en_c), DW'(64));
        check_val("bound_no_timeout", DW'(timeout), '0);

        // 5: memory never acks -> abort after 64 grant cycles
        lat = 0;
        do_txn(0, 1'b0, 32'h20, '0, en_c, ac, rd, fg, fw, fa);
        check_val("t5_enable_cycles", DW'(en_c), DW'(64));
        check_val("t5_no_ack", DW'(ac), '0);
        check_val("t5_timeout", DW'(timeout), DW'(1));
        lat = 2;
        do_txn(1, 1'b0, 32'h40, '0, en_c, ac, rd, fg, fw, fa);
        check_val("t5_next_served", DW'(ac), DW'(1));
        check_val("t5_timeout_sticky", DW'(timeout), DW'(1));

        // 6: reset 3 cycles into a grant, later stray ack ignored
        lat = 0;
        set_req(0, 1'b1, 1'b0, 32'h20, '0);
        repeat (3) @(negedge clk);
        check_val("t6_in_grant", DW'(grant), DW'(2'b01));
        rst = 1'b1;
        @(negedge clk);
        check_val("t6_enable", DW'(mem_en), '0);
        check_val("t6_grant", DW'(grant), DW'(2'b00));
        check_val("t6_timeout", DW'(timeout), '0);
        rst = 1'b0;
        set_req(0, 1'b0, 1'b0, '0, '0);
        ack_inj = 1'b1;
        #1;
        check_val("t6_stray_ack", DW'({req1_ack, req0_ack}), '0);
        @(negedge clk);
        ack_inj = 1'b0;
        check_val("t6_still_idle", DW'({mem_en, grant}), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
